id_fsm: RTL and testbench



---
 rtl/id_fsm.sv | 51 +++++
 tb/tb_id_fsm.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/id_fsm.sv
// Identifier recognizer: letters followed by digits on an ASCII stream.
// Moore output is high while the registered state is DIGIT.
module id_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char,
  output logic       out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ALPHA = 2'b01,
    S_DIGIT = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   is_letter;
  logic   is_digit;

  always_comb begin
    is_letter = ((char >= 8'd65) && (char <= 8'd90)) ||
                ((char >= 8'd97) && (char <= 8'd122));
    is_digit  = (char >= 8'd48) && (char <= 8'd57);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    unique case (state_q)
      S_IDLE: begin
        if (is_letter) state_d = S_ALPHA;
      end
      S_ALPHA, S_DIGIT: begin
        if (is_letter)     state_d = S_ALPHA;
        else if (is_digit) state_d = S_DIGIT;
      end
      // The spare encoding falls back to IDLE.
      default: state_d = S_IDLE;
    endcase
  end

  assign out = (state_q == S_DIGIT);

endmodule

// File: tb/tb_id_fsm.sv
// Directed bench for id_fsm: character streams with hand-computed out values.
module tb_id_fsm;

  logic       clk;
  logic       reset;
  logic [7:0] ch;
  logic       out_w;

  int unsigned checks = 0;
  int unsigned errors = 0;

  id_fsm dut (
    .clk   (clk),
    .reset (reset),
    .char  (ch),
    .out   (out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input string tag, input logic [7:0] c, input logic exp);
    @(negedge clk);
    ch = c;
    @(posedge clk);
    #1;
    check(tag, out_w, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_out", out_w, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ch    = 8'd0;
    #2;
    check("por_out", out_w, 1'b0);
    // Edges under reset must not be processed.
    ch = 8'd97;
    @(posedge clk); #1;
    check("hold_a", out_w, 1'b0);
    @(negedge clk);
    ch = 8'd49;
    @(posedge clk); #1;
    check("hold_1", out_w, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // "1ab12%"
    step("s1_1", 8'd49, 1'b0);
    step("s1_a", 8'd97, 1'b0);
    step("s1_b", 8'd98, 1'b0);
    step("s1_1b", 8'd49, 1'b1);
    step("s1_2", 8'd50, 1'b1);
    step("s1_pct", 8'd37, 1'b0);

    // "Z9x7": a letter after DIGIT restarts the match
    do_reset();
    step("s2_Z", 8'd90, 1'b0);
    step("s2_9", 8'd57, 1'b1);
    step("s2_x", 8'd120, 1'b0);
    step("s2_7", 8'd55, 1'b1);

    // Digit range edges: '/' and ':' drop ALPHA to IDLE
    do_reset();
    step("b_a0", 8'd97, 1'b0);
    step("b_slash", 8'd47, 1'b0);
    step("b_slash_d", 8'd49, 1'b0);
    step("b_a1", 8'd97, 1'b0);
    step("b_colon", 8'd58, 1'b0);
    step("b_colon_d", 8'd49, 1'b0);
    step("b_a2", 8'd97, 1'b0);
    step("b_0", 8'd48, 1'b1);
    step("b_9", 8'd57, 1'b1);

    // Letter range edges: neighbours never enter ALPHA
    step("b_at", 8'd64, 1'b0);
    step("b_at_d", 8'd49, 1'b0);
    step("b_lbr", 8'd91, 1'b0);
    step("b_lbr_d", 8'd49, 1'b0);
    step("b_bq", 8'd96, 1'b0);
    step("b_bq_d", 8'd49, 1'b0);
    step("b_lcb", 8'd123, 1'b0);
    step("b_lcb_d", 8'd49, 1'b0);
    step("b_A", 8'd65, 1'b0);
    step("b_A_d", 8'd49, 1'b1);
    step("b_sp", 8'd32, 1'b0);
    step("b_z", 8'd122, 1'b0);
    step("b_z_d", 8'd49, 1'b1);

    // Digits only, then OTHER only
    do_reset();
    step("d_1", 8'd49, 1'b0);
    step("d_2", 8'd50, 1'b0);
    step("d_3", 8'd51, 1'b0);
    step("o_32", 8'd32, 1'b0);
    step("o_255", 8'd255, 1'b0);
    step("o_0", 8'd0, 1'b0);
    step("o_0_d", 8'd49, 1'b0);

    // Asynchronous reset mid-match
    step("r_a", 8'd97, 1'b0);
    step("r_1", 8'd49, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("r_async", out_w, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step("r_2", 8'd50, 1'b0);

    // Long run: 'q' then 20 digits, then space
    step("l_q", 8'd113, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("l_d%0d", i), 8'(8'd48 + 8'(i % 10)), 1'b1);
    end
    step("l_sp", 8'd32, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
